// File: rtl/sram_arb_pkg.sv
// Shared state encoding, direction constants and parameter defaults for sram_arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_MAX_RD_RUN = 8;
    localparam int DEF_TIMEOUT    = 15;

    // rd_run must hold MAX_RD_RUN itself and is never narrower than 3 bits.
    function automatic int run_width(input int max_run);
        int w;
        w = $clog2(max_run + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/sram_arb_timer.sv
// WAIT-state watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
// Latency: expire is combinational from the count, so the owner can leave WAIT on that edge.
// Backpressure: none; clr has priority over en.
module sram_arb_timer
    import sram_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Read-priority arbiter sharing one SRAM controller port; WAIT timeout + err_out under SRAM_ARB_TIMEOUT_EN.
// Latency: req sampled at edge k -> trig_out in cycle k+1 -> ack 3 cycles after trig (2-edge controller).
// Backpressure: requesters hold req until ack; one transaction in flight, no preemption.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_RD_RUN = DEF_MAX_RD_RUN,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_ack,
    output logic [7:0]  rd_data,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        trig_out,
    output logic        rw_out,
    output logic [18:0] addr_out,
    output logic [7:0]  w_data_out,
    input  logic [7:0]  r_data_in,
`ifdef SRAM_ARB_TIMEOUT_EN
    output logic        err_out,
`endif
    input  logic        done_in
);

    localparam int RUN_W = run_width(MAX_RD_RUN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

    arb_state_t       state;
    logic             gnt_rd;
    logic [RUN_W-1:0] rd_run;
    logic             grant_rd;
    logic             grant_wr;

    // Reads win unless a pending write has already watched MAX_RD_RUN reads go by.
    assign grant_rd = rd_req && !(wr_req && (rd_run == RUN_MAX));
    assign grant_wr = wr_req && !grant_rd;

`ifdef SRAM_ARB_TIMEOUT_EN
    logic tmr_expire;

    sram_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_WAIT),
        .en     (state == ST_WAIT),
        .expire (tmr_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            gnt_rd     <= 1'b0;
            rd_run     <= '0;
            trig_out   <= 1'b0;
            rw_out     <= RW_READ;
            addr_out   <= '0;
            w_data_out <= '0;
            rd_data    <= '0;
            rd_ack     <= 1'b0;
            wr_ack     <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
            err_out    <= 1'b0;
`endif
        end else begin
            trig_out <= 1'b0;
            rd_ack   <= 1'b0;
            wr_ack   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_rd) begin
                        gnt_rd   <= 1'b1;
                        rw_out   <= RW_READ;
                        addr_out <= rd_addr;
                        trig_out <= 1'b1;
                        state    <= ST_ISSUE;
                        if (!wr_req) begin
                            rd_run <= '0;
                        end else if (rd_run != RUN_MAX) begin
                            rd_run <= rd_run + RUN_W'(1);
                        end
                    end else if (grant_wr) begin
                        gnt_rd     <= 1'b0;
                        rw_out     <= RW_WRITE;
                        addr_out   <= wr_addr;
                        w_data_out <= wr_data;
                        trig_out   <= 1'b1;
                        rd_run     <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!done_in) begin
                        if (gnt_rd) begin
                            rd_data <= r_data_in;
                        end
                        rd_ack <= gnt_rd;
                        wr_ack <= !gnt_rd;
                        state  <= ST_ACK;
                    end
`ifdef SRAM_ARB_TIMEOUT_EN
                    else if (tmr_expire) begin
                        rd_ack  <= gnt_rd;
                        wr_ack  <= !gnt_rd;
                        err_out <= 1'b1;
                        state   <= ST_ACK;
                    end
`endif
                end
                ST_ACK: begin
                    rw_out <= RW_READ;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed steps plus randomized traffic against a
// transaction-level reference model (priority rule, read-run count, byte memory).
module tb_sram_arbiter;

    localparam int MAXR = 8;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        trig_out;
    logic        rw_out;
    logic [18:0] addr_out;
    logic [7:0]  w_data_out;
    logic [7:0]  r_data_in = 8'h00;
    logic        done_in   = 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
    logic        err_out;
`endif

    always #5 clk = ~clk;

    sram_arbiter #(
        .MAX_RD_RUN (MAXR),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .trig_out   (trig_out),
        .rw_out     (rw_out),
        .addr_out   (addr_out),
        .w_data_out (w_data_out),
        .r_data_in  (r_data_in),
`ifdef SRAM_ARB_TIMEOUT_EN
        .err_out    (err_out),
`endif
        .done_in    (done_in)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_run  = 0;
    logic [7:0]  last_rd = 8'h00;
    logic [7:0]  ref_mem [logic [18:0]];
    int          e_rd = 0, e_wr = 0, e_trig = 0;
    int          n_rd_ack = 0, n_wr_ack = 0, n_trig = 0;
    logic [18:0] pool [8];
    bit          was_rd;

    // Controller model state
    logic [7:0]  ctl_mem [logic [18:0]];
    bit          ctl_hang = 1'b0;
    logic [18:0] c_a;
    logic        c_rw;
    logic [7:0]  c_d;

    function automatic logic [7:0] dflt(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    function automatic logic [7:0] ref_rd(input logic [18:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Controller: drops done_in for one cycle two edges after seeing the strobe.
    always @(posedge clk) begin
        #1;
        if (trig_out === 1'b1 && !ctl_hang) begin
            c_a  = addr_out;
            c_rw = rw_out;
            c_d  = w_data_out;
            @(posedge clk);
            @(posedge clk);
            #1;
            done_in = 1'b0;
            if (c_rw) r_data_in = ctl_mem.exists(c_a) ? ctl_mem[c_a] : dflt(c_a);
            else      ctl_mem[c_a] = c_d;
            @(posedge clk);
            #1;
            done_in   = 1'b1;
            r_data_in = 8'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rd_ack === 1'b1)   n_rd_ack++;
        if (wr_ack === 1'b1)   n_wr_ack++;
        if (trig_out === 1'b1) n_trig++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic raise_rd();
        rd_addr = pool[$urandom_range(0, 7)];
        rd_req  = 1'b1;
    endtask

    task automatic raise_wr();
        wr_addr = pool[$urandom_range(0, 7)];
        wr_data = 8'($urandom);
        wr_req  = 1'b1;
    endtask

    task automatic check_reset_vals();
        chk("rst_trig_out", trig_out, 0);
        chk("rst_rw_out", rw_out, 1);
        chk("rst_addr_out", addr_out, 0);
        chk("rst_w_data_out", w_data_out, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_wr_ack", wr_ack, 0);
`ifdef SRAM_ARB_TIMEOUT_EN
        chk("rst_err_out", err_out, 0);
`endif
    endtask

    // Predicts the winner from the pending requests, then follows it from strobe to ack.
    task automatic expect_txn(input int ack_dly, input bit hang, input bit mid_raise,
                              output bit got_rd);
        bit          e_isrd;
        bit          wr_pend;
        logic [18:0] ea;
        logic [7:0]  ed;
        logic [7:0]  er;
        int          n;
        wr_pend = wr_req;
        e_isrd  = rd_req && !(wr_req && m_run >= MAXR);
        ea      = e_isrd ? rd_addr : wr_addr;
        ed      = wr_data;
        er      = hang ? last_rd : ref_rd(ea);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (trig_out !== 1'b1 && n < 20);
        chk("req_to_trig_cycles", n, 1);
        chk("trig_out", trig_out, 1);
        chk("rw_out", rw_out, e_isrd);
        chk("addr_out", addr_out, ea);
        if (!e_isrd) chk("w_data_out", w_data_out, ed);
        e_trig++;
        for (int i = 1; i < ack_dly; i++) begin
            @(posedge clk); #1;
            if (mid_raise && i == 1) begin
                if (!rd_req && $urandom_range(0, 3) == 0) raise_rd();
                if (!wr_req && $urandom_range(0, 3) == 0) raise_wr();
            end
            chk("trig_one_cycle", trig_out, 0);
            chk("hold_rw_out", rw_out, e_isrd);
            chk("hold_addr_out", addr_out, ea);
            if (!e_isrd) chk("hold_w_data_out", w_data_out, ed);
            chk("early_ack", {rd_ack, wr_ack}, 0);
        end
        @(posedge clk); #1;
        chk("rd_ack", rd_ack, e_isrd);
        chk("wr_ack", wr_ack, !e_isrd);
        if (e_isrd) begin
            chk("rd_data", rd_data, er);
            rd_req  = 1'b0;
            last_rd = er;
            m_run   = wr_pend ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
            e_rd++;
        end else begin
            chk("rd_data_held", rd_data, last_rd);
            wr_req = 1'b0;
            if (!hang) ref_mem[ea] = ed;
            m_run = 0;
            e_wr++;
        end
        got_rd = e_isrd;
        @(posedge clk); #1;
        chk("ack_one_cycle", {rd_ack, wr_ack}, 0);
        chk("idle_rw_out", rw_out, 1);
        chk("idle_no_trig", trig_out, 0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        pool[0] = 19'h40010;
        pool[1] = 19'h00123;
        for (int i = 2; i < 8; i++) pool[i] = 19'($urandom);

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk); rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_reset_no_trig", trig_out, 0);
        end

        // Single read
        ctl_mem[19'h40010] = 8'hA5;
        ref_mem[19'h40010] = 8'hA5;
        @(negedge clk);
        rd_addr = 19'h40010; rd_req = 1'b1;
        expect_txn(3, 1'b0, 1'b0, was_rd);
        chk("single_read_data", rd_data, 8'hA5);

        // Single write
        @(negedge clk);
        wr_addr = 19'h00123; wr_data = 8'h3C; wr_req = 1'b1;
        expect_txn(3, 1'b0, 1'b0, was_rd);
        chk("single_write_is_wr", was_rd, 0);

        // Simultaneous requests: read first, then write
        @(negedge clk);
        rd_addr = 19'h00123; rd_req = 1'b1;
        wr_addr = pool[5]; wr_data = 8'h5A; wr_req = 1'b1;
        expect_txn(3, 1'b0, 1'b0, was_rd);
        chk("simul_first_is_rd", was_rd, 1);
        chk("simul_rd_sees_write", rd_data, 8'h3C);
        @(negedge clk);
        expect_txn(3, 1'b0, 1'b0, was_rd);
        chk("simul_second_is_wr", was_rd, 0);

        // Starvation guard: both held continuously -> 8 reads, 1 write, repeat
        for (int t = 0; t < 18; t++) begin
            @(negedge clk);
            if (!rd_req) raise_rd();
            if (!wr_req) raise_wr();
            expect_txn(3, 1'b0, 1'b0, was_rd);
            chk("starve_pattern", was_rd, (t % 9) != 8);
        end

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!rd_req && $urandom_range(0, 2) != 0) raise_rd();
            if (!wr_req && $urandom_range(0, 2) != 0) raise_wr();
            if (!rd_req && !wr_req) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    chk("gap_no_trig", trig_out, 0);
                end
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) raise_rd();
                else raise_wr();
            end
            expect_txn(3, 1'b0, 1'b1, was_rd);
        end
        for (int t = 0; t < 2; t++) begin
            if (rd_req || wr_req) begin
                @(negedge clk);
                expect_txn(3, 1'b0, 1'b0, was_rd);
            end
        end

`ifdef SRAM_ARB_TIMEOUT_EN
        // Timeout: controller never completes
        ctl_hang = 1'b1;
        @(negedge clk); raise_rd();
        expect_txn(TMO + 1, 1'b1, 1'b0, was_rd);
        chk("timeout_err_set", err_out, 1);
        ctl_hang = 1'b0;
        @(negedge clk); raise_wr();
        expect_txn(3, 1'b0, 1'b0, was_rd);
        chk("timeout_err_sticky", err_out, 1);
`endif

        // Reset asserted while in WAIT
        ctl_hang = 1'b1;
        @(negedge clk); raise_wr();
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (trig_out !== 1'b1 && n < 10);
        chk("midrst_trig_seen", trig_out, 1);
        e_trig++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals();
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_ack", {rd_ack, wr_ack}, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        ctl_hang = 1'b0;
        m_run = 0;
        last_rd = 8'h00;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_idle_no_trig", trig_out, 0);
            chk("midrst_idle_no_ack", {rd_ack, wr_ack}, 0);
        end
        @(negedge clk); raise_rd();
        expect_txn(3, 1'b0, 1'b0, was_rd);
        chk("midrst_recover_rd", was_rd, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("total_rd_acks", n_rd_ack, e_rd);
        chk("total_wr_acks", n_wr_ack, e_wr);
        chk("total_trigs", n_trig, e_trig);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer in front of the byte-wide SRAM controller in the VGA design. It shares the single SRAM port between a high-priority video read requester (the scan-out fetch) and a low-priority write requester (frame-buffer updates). It issues one transaction at a time, holds address, direction and write data stable until the controller signals completion, and returns read data and acknowledgements. A starvation guard ensures that pending writes are eventually served during continuous read traffic.

## Interface
- `MAX_RD_RUN`, default 8: maximum consecutive read grants while a write is pending.
- `TIMEOUT`, default 15: cycles spent in WAIT before a transaction is aborted. Only used with `SRAM_ARB_TIMEOUT_EN`.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_req` in 1: read request. Held high until `rd_ack`.
- `rd_addr` in 19: read byte address. Bit 18 selects the upper byte.
- `rd_ack` out 1: one-cycle pulse that completes a read.
- `rd_data` out 8: read data. Valid in the cycle `rd_ack` is high and held until the next read completes.
- `wr_req` in 1: write request. Held high until `wr_ack`.
- `wr_addr` in 19: write byte address.
- `wr_data` in 8: write byte.
- `wr_ack` out 1: one-cycle pulse that completes a write.
- `trig_out` out 1: one-cycle transaction strobe to the controller.
- `rw_out` out 1: direction to the controller, 1 = read, 0 = write.
- `addr_out` out 19: address to the controller.
- `w_data_out` out 8: write data to the controller.
- `r_data_in` in 8: read data from the controller.
- `done_in` in 1: controller status. Low for one cycle marks transaction completion.
- `err_out` out 1: sticky timeout flag. Present only with `SRAM_ARB_TIMEOUT_EN`.

## Operation
- **States:** IDLE, ISSUE, WAIT, ACK.
- **IDLE:** arbitrate among the pending requests.
  - If only one requester is pending, grant it.
  - If both are pending, grant read unless `rd_run == MAX_RD_RUN`, in which case grant write.
  - On a grant, register `rw_out`, `addr_out` and `w_data_out` from the winner, then go to ISSUE.
- **ISSUE:** `trig_out` = 1 for exactly one cycle, then go to WAIT. `done_in` is ignored during ISSUE.
- **WAIT:** `rw_out`, `addr_out` and `w_data_out` are held stable.
  - When `done_in` == 0: capture `r_data_in` into `rd_data` (reads only), then go to ACK.
- **ACK:** pulse `rd_ack` or `wr_ack` (granted port only) for one cycle, then go to IDLE.
  - A requester that keeps `req` high in the ACK cycle re-requests. The sampling in IDLE happens after `ack`, so a requester must drop `req` in the cycle after `ack` to avoid a duplicate transaction.
- **`rd_run` counter (3+ bits, saturating at `MAX_RD_RUN`):**
  - Increments on each read grant made while `wr_req` is high.
  - Clears on a write grant.
  - Clears when `wr_req` is low at a read grant.
- **Outputs between transactions:** `rw_out` returns to 1 in IDLE. `addr_out` and `w_data_out` keep their last values.
- **Simultaneous events:**
  - A new `req` arriving during ISSUE, WAIT or ACK waits until IDLE. There is no preemption.
  - Both requests rising in the same cycle are resolved by the priority rule above.

## Timing
- **Reset values:** `trig_out` = 0, `rw_out` = 1, `addr_out` = 0, `w_data_out` = 0, `rd_data` = 0, `rd_ack` = 0, `wr_ack` = 0, `err_out` = 0, `rd_run` = 0. State resets to IDLE.
- **Nominal latency** with a controller that drops `done_in` two edges after the strobe:
  - `req` sampled at edge k.
  - `trig_out` high in cycle k+1.
  - `done_in` low observed at edge k+3.
  - `ack` high in cycle k+4.
  - Throughput is one transaction per 5 cycles per port.
- **Reset asserted mid-transaction:** the transaction is abandoned immediately. No `ack` is issued. The requester must re-request.
- **Address and data stability:** `addr_out`, `rw_out` and `w_data_out` never change between ISSUE and the exit from WAIT.

## Configuration
- **`SRAM_ARB_TIMEOUT_EN` defined:**
  - A WAIT cycle counter runs. When it reaches `TIMEOUT` with no `done_in` low, the arbiter goes to ACK.
  - The granted port receives an `ack`; `rd_data` is unchanged on a read.
  - `err_out` sets and stays set until reset.
- **`SRAM_ARB_TIMEOUT_EN` undefined:** WAIT holds indefinitely. `err_out` and the counter are absent.

## Structure
- **Package `sram_arb_pkg`:** state encoding localparams (IDLE/ISSUE/WAIT/ACK), the read/write direction constants, and the default `MAX_RD_RUN`/`TIMEOUT`.
- **Sub-module `sram_arb_timer`:** WAIT timeout counter with clear, enable and expire outputs. Instantiated only under `SRAM_ARB_TIMEOUT_EN`.
- **Top level:** FSM, priority logic and `rd_run` counter stay in `sram_arbiter`.

## Test plan
1. **Reset:** hold `rst` = 0, then release → all outputs at their reset values, no `trig_out` until a `req` arrives.
2. **Single read:** `rd_req` with `rd_addr` = 0x40010, model returns 0xA5 → `trig_out` one cycle with `rw_out` = 1 and `addr_out` = 0x40010, then `rd_ack` one cycle with `rd_data` = 0xA5.
3. **Single write:** `wr_req` with `wr_addr` = 0x00123 and `wr_data` = 0x3C → `rw_out` = 0, `w_data_out` = 0x3C held through WAIT, one `wr_ack`, no `rd_ack`.
4. **Simultaneous requests:** `rd_req` and `wr_req` rise in the same cycle → read served first, then write.
5. **Starvation guard:** `rd_req` held continuously, `wr_req` held, `MAX_RD_RUN` = 8 → exactly 8 reads, then 1 write, pattern repeats.
6. **Timeout and mid-transaction reset:** model never drops `done_in` with `SRAM_ARB_TIMEOUT_EN`, `TIMEOUT` = 15 → `ack` after 15 WAIT cycles and `err_out` = 1. Separately, reset asserted in WAIT → no `ack`, state IDLE, outputs at reset values.
